// File: rtl/pico_ctrl.sv
// pico_ctrl: picoMips fetch/decode/sequencer driving the accumulator ALU, with RUN/WAIT/HALT control.
// Optional PICO_READY_SYNC_EN adds a 2-flop synchroniser on Ready ahead of edge detection.
module pico_ctrl #(
  parameter int PCW = 6
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [11:0]    Instr,
  input  logic [7:0]     Acc,
  input  logic [7:0]     SwIn,
  input  logic           Ready,
  output logic [PCW-1:0] PC,
  output logic [7:0]     DataA,
  output logic [7:0]     DataB,
  output logic           WE,
  output logic           UseA,
  output logic           UseMul,
  output logic [7:0]     Out,
  output logic           Halted
);
  typedef enum logic [1:0] {RUN, WAIT, HALT} state_e;
  state_e state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d, pc_inc, tgt;
  logic [7:0] out_q, out_d, imm;
  logic [3:0] op;
  logic rdy, rdy_prev_q, rise, run;
`ifdef PICO_READY_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge Clock) begin
    if (Reset) sync_q <= 2'b00;
    else sync_q <= {sync_q[0], Ready};
  end
  assign rdy = sync_q[1];
`else
  assign rdy = Ready;
`endif
  assign op = Instr[11:8];
  assign imm = Instr[7:0];
  assign tgt = imm[PCW-1:0];
  assign pc_inc = pc_q + PCW'(1);
  assign rise = rdy & ~rdy_prev_q;
  assign run = (state_q == RUN) && !Reset;
  always_comb begin
    DataA = (op == 4'h2 || op == 4'h3) ? Acc : (op == 4'h4 || op == 4'h5) ? SwIn : 8'h00;
    DataB = (op inside {4'h1, 4'h2, 4'h3, 4'h5}) ? imm : 8'h00;
    WE = run && (op inside {[4'h1:4'h5]});
    UseA = run && (op inside {[4'h2:4'h5]});
    UseMul = run && (op == 4'h3);
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    out_d = out_q;
    case (state_q)
      RUN: begin
        pc_d = pc_inc;
        case (op)
          4'h6: out_d = Acc;
          4'h7: begin pc_d = pc_q; state_d = WAIT; end
          4'h8: pc_d = tgt;
          4'h9: pc_d = (Acc == 8'h00) ? tgt : pc_inc;
          4'hA: pc_d = Acc[7] ? tgt : pc_inc;
          4'hF: begin pc_d = pc_q; state_d = HALT; end
          default: ;
        endcase
      end
      WAIT: if (rise) begin pc_d = pc_inc; state_d = RUN; end
      default: ;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q <= '0;
      out_q <= 8'h00;
      rdy_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      rdy_prev_q <= rdy;
    end
  end
  assign PC = pc_q;
  assign Out = out_q;
  assign Halted = (state_q == HALT);
endmodule

// File: tb/tb_pico_ctrl.sv
// tb_pico_ctrl: directed test-plan sequences plus randomized cycles against a behavioural model of pico_ctrl.
module tb_pico_ctrl;
`ifdef PICO_READY_SYNC_EN
  localparam int REL = 3;
`else
  localparam int REL = 1;
`endif
  logic Clock = 1'b0;
  logic Reset, Ready, WE, UseA, UseMul, Halted;
  logic [11:0] Instr;
  logic [7:0] Acc, SwIn, DataA, DataB, Out;
  logic [5:0] PC;
  int checks = 0, failures = 0;
  int m_pc = 0, m_mode = 0;
  logic [7:0] m_out = 8'h00;
  logic m_prev = 1'b0;
  logic [1:0] hist = 2'b00;

  always #5 Clock = ~Clock;

  pico_ctrl #(.PCW(6)) dut (
    .Clock(Clock), .Reset(Reset), .Instr(Instr), .Acc(Acc), .SwIn(SwIn), .Ready(Ready),
    .PC(PC), .DataA(DataA), .DataB(DataB), .WE(WE), .UseA(UseA), .UseMul(UseMul),
    .Out(Out), .Halted(Halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ready as seen by the WAIT release logic: raw, or delayed two samples when synchronised.
  function automatic logic eff_ready();
`ifdef PICO_READY_SYNC_EN
    return hist[1];
`else
    return Ready;
`endif
  endfunction

  task automatic cyc(input logic [11:0] ins, input logic [7:0] acc, input logic [7:0] sw,
                     input logic rdy, input logic rst);
    logic [3:0] op;
    logic [7:0] imm;
    logic run, e;
    Instr = ins; Acc = acc; SwIn = sw; Ready = rdy; Reset = rst;
    op = ins[11:8];
    imm = ins[7:0];
    run = (m_mode == 0) && !rst;
    #3;
    check("dataA", DataA, (op == 2 || op == 3) ? acc : (op == 4 || op == 5) ? sw : 8'h00);
    check("dataB", DataB, (op == 1 || op == 2 || op == 3 || op == 5) ? imm : 8'h00);
    check("we", WE, run && op >= 1 && op <= 5);
    check("useA", UseA, run && op >= 2 && op <= 5);
    check("useMul", UseMul, run && op == 3);
    @(posedge Clock);
    e = eff_ready();
    if (rst) begin
      m_pc = 0; m_out = 8'h00; m_mode = 0;
    end else if (m_mode == 0) begin
      case (op)
        4'h6: begin m_out = acc; m_pc = (m_pc + 1) % 64; end
        4'h7: m_mode = 1;
        4'h8: m_pc = imm % 64;
        4'h9: m_pc = (acc == 0) ? imm % 64 : (m_pc + 1) % 64;
        4'hA: m_pc = acc[7] ? imm % 64 : (m_pc + 1) % 64;
        4'hF: m_mode = 2;
        default: m_pc = (m_pc + 1) % 64;
      endcase
    end else if (m_mode == 1 && e && !m_prev) begin
      m_pc = (m_pc + 1) % 64;
      m_mode = 0;
    end
    m_prev = rst ? 1'b0 : e;
    hist = rst ? 2'b00 : {hist[0], rdy};
    #1;
    check("pc", PC, m_pc);
    check("out", Out, m_out);
    check("halted", Halted, m_mode == 2);
  endtask

  initial begin
    int n;
    logic [5:0] pc_frozen;
    logic rdy;
    logic [11:0] ins;
    logic [7:0] acc;
    cyc(12'h000, 8'h00, 8'h00, 1'b0, 1'b1);
    cyc(12'h000, 8'h00, 8'h00, 1'b0, 1'b1);
    check("rst_pc", PC, 0);
    check("rst_out", Out, 8'h00);
    check("rst_halted", Halted, 1'b0);
    // LDI 5; ADDI 3; OUT with the ALU result fed back by hand
    cyc(12'h105, 8'h00, 8'h00, 1'b1, 1'b0);
    cyc(12'h203, 8'h05, 8'h00, 1'b1, 1'b0);
    cyc(12'h600, 8'h08, 8'h00, 1'b1, 1'b0);
    check("prog_out", Out, 8'h08);
    check("prog_pc", PC, 3);
    // WAIT entered with Ready already high must not release
    cyc(12'h700, 8'h08, 8'h00, 1'b1, 1'b0);
    repeat (5) cyc(12'h000, 8'h08, 8'h00, 1'b1, 1'b0);
    check("wait_hold_hi", PC, 3);
    repeat (2) cyc(12'h000, 8'h08, 8'h00, 1'b0, 1'b0);
    check("wait_hold_lo", PC, 3);
    n = 0;
    while (PC == 6'd3 && n < 8) begin
      cyc(12'h000, 8'h08, 8'h00, 1'b1, 1'b0);
      n++;
    end
    check("wait_latency", n, REL);
    check("wait_pc", PC, 4);
    cyc(12'h910, 8'h00, 8'h00, 1'b1, 1'b0);
    check("bz_taken", PC, 6'h10);
    cyc(12'h910, 8'h01, 8'h00, 1'b1, 1'b0);
    check("bz_not", PC, 6'h11);
    cyc(12'hA20, 8'h80, 8'h00, 1'b1, 1'b0);
    check("bneg_taken", PC, 6'h20);
    cyc(12'h83F, 8'h00, 8'h00, 1'b1, 1'b0);
    check("jmp_pc", PC, 6'h3F);
    cyc(12'h000, 8'h00, 8'h00, 1'b1, 1'b0);
    check("wrap_pc", PC, 6'h00);
    cyc(12'h511, 8'h00, 8'h22, 1'b1, 1'b0);
    cyc(12'hF00, 8'h00, 8'h00, 1'b1, 1'b0);
    check("halt", Halted, 1'b1);
    pc_frozen = PC;
    repeat (20) cyc(12'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    check("halt_pc", PC, pc_frozen);
    cyc(12'h000, 8'h00, 8'h00, 1'b0, 1'b1);
    check("halt_rst_pc", PC, 0);
    check("halt_rst_halted", Halted, 1'b0);
    check("halt_rst_out", Out, 8'h00);
    rdy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ins = 12'($urandom);
      if (ins[11:8] == 4'hF && $urandom_range(3) != 0) ins[11:8] = 4'h0;
      case ($urandom_range(3))
        0: acc = 8'h00;
        1: acc = 8'h80 | 8'($urandom_range(127));
        default: acc = 8'($urandom);
      endcase
      if ($urandom_range(3) == 0) rdy = ~rdy;
      cyc(ins, acc, 8'($urandom), rdy, $urandom_range(39) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
